// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-only memory: sub-word loads are extracted and extended, sub-word stores are read-modify-write.
// Latency accept->rsp_valid: 1 (fault), 2 (load, store W), 3 (store B/H); req_ready is high only in IDLE, and no response is ever held.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WR,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t            state;
  state_t            state_n;
  logic              accept;
  logic              req_illegal;
  logic              req_misaligned;
  logic              req_bad;

  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       rdata_q;
  logic              fault_q;

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [31:0]       merged;

  // Request legality is judged on the live request so a fault can skip straight to RESP.
  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      F3_BU, F3_HU:           req_illegal = req_we;
      default:                req_illegal = 1'b0;
    endcase
    req_misaligned = 1'b0;
    case (req_funct3)
      F3_H, F3_HU: req_misaligned = req_addr[0];
      F3_W:        req_misaligned = |req_addr[1:0];
      default:     req_misaligned = 1'b0;
    endcase
    req_bad = req_illegal | req_misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    accept       = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_read     = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_bad) begin
            state_n = RESP;
          end else if (!req_we) begin
            state_n = LOAD;
          end else if (req_funct3 == F3_W) begin
            state_n = WR;
          end else begin
            state_n = RMW_RD;
          end
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        state_n  = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        state_n  = WR;
      end
      WR: begin
        // A reset landing on the write cycle must leave memory untouched.
        mem_write_en = !rst;
        state_n      = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Little-endian lane select on the returned word, then sign or zero extension.
  always_comb begin
    ld_byte = mem_read_data[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = mem_read_data[15:8];
      2'd2:    ld_byte = mem_read_data[23:16];
      2'd3:    ld_byte = mem_read_data[31:24];
      default: ld_byte = mem_read_data[7:0];
    endcase
    ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (funct3_q)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_ext = {24'h0, ld_byte};
      F3_HU:   ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_read_data;
    endcase
  end

  always_comb begin
    merged = mem_read_data;
    if (funct3_q == F3_B) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Response registers only change on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      funct3_q <= 3'h0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      fault_q  <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        if (req_bad) begin
          rdata_q <= 32'h0;
          fault_q <= 1'b1;
        end
      end
      if (state == LOAD) begin
        rdata_q <= ld_ext;
        fault_q <= 1'b0;
      end
      if (state == RMW_RD) begin
        merge_q <= merged;
      end
      if (state == WR) begin
        rdata_q <= 32'h0;
        fault_q <= 1'b0;
      end
    end
  end

  assign rsp_rdata       = rdata_q;
  assign rsp_fault       = fault_q;
  assign mem_access_addr = (mem_read || mem_write_en) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_write_data  = mem_write_en ? ((funct3_q == F3_W) ? wdata_q : merge_q) : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: small word memory, expected responses queued at issue and checked on rsp_valid.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_write_data;
  logic        mem_write_en;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] dmem [0:63];
  logic [31:0] ref_mem [0:15];
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] waddr;
  } exp_t;
  exp_t exp_q[$];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  assign mem_read_data = dmem[mem_access_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write_en) dmem[mem_access_addr[7:2]] <= mem_write_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [31:0] rd, input logic f, input int lat,
                              input logic wr, input logic [31:0] wd, input logic [31:0] wa);
    exp_t e;
    e.rdata = rd; e.fault = f; e.lat = lat; e.wr = wr; e.wdata = wd; e.waddr = wa;
    return e;
  endfunction

  // Reference behaviour computed with shifts and masks over the shadow memory.
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd);
    exp_t e;
    logic [31:0] word, v, mask;
    logic bad;
    int sh;
    word = ref_mem[addr[5:2]];
    sh = int'(addr[1:0]) * 8;
    bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5))
       || (((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) || ((f3 == 3'd2) && (addr[1:0] != 2'd0));
    e = mk(32'h0, bad, bad ? 1 : ((we && f3 != 3'd2) ? 3 : 2), !bad && we, 32'h0, {addr[31:2], 2'b00});
    if (!bad && !we) begin
      v = word >> sh;
      case (f3)
        3'd0: e.rdata = {{24{v[7]}}, v[7:0]};
        3'd1: e.rdata = {{16{v[15]}}, v[15:0]};
        3'd4: e.rdata = {24'h0, v[7:0]};
        3'd5: e.rdata = {16'h0, v[15:0]};
        default: e.rdata = word;
      endcase
    end
    if (!bad && we) begin
      mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
      mask = mask << sh;
      e.wdata = (word & ~mask) | ((wd << sh) & mask);
    end
    return e;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input exp_t e);
    exp_t g;
    int w, lat, wr_cyc;
    bit done, wr_seen, rd_seen, both;
    logic [31:0] wr_dat, wr_adr;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    lat = 0; done = 0; wr_seen = 0; rd_seen = 0; both = 0; wr_cyc = 0; wr_dat = 0; wr_adr = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_read && mem_write_en) both = 1;
      if (mem_read) rd_seen = 1;
      if (mem_write_en) begin wr_seen = 1; wr_cyc = lat; wr_dat = mem_write_data; wr_adr = mem_access_addr; end
      if (rsp_valid) done = 1;
    end
    g = exp_q.pop_front();
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL rsp_timeout f3=%0d addr=%h: got no rsp_valid, want rsp within %0d cycles", f3, addr, g.lat);
    end else begin
      n_tests++;
      if (lat !== g.lat) begin n_fail++; $display("FAIL latency addr=%h f3=%0d: got %0d want %0d", addr, f3, lat, g.lat); end
      if (rsp_rdata !== g.rdata) begin n_fail++; $display("FAIL rdata addr=%h f3=%0d: got %h want %h", addr, f3, rsp_rdata, g.rdata); end
      n_tests++;
      if (rsp_fault !== g.fault) begin n_fail++; $display("FAIL fault addr=%h f3=%0d: got %b want %b", addr, f3, rsp_fault, g.fault); end
    end
    n_tests++;
    if (both) begin n_fail++; $display("FAIL strobes_both addr=%h: got read&write together, want exclusive", addr); end
    n_tests++;
    if (rd_seen !== (!g.fault && !(we && f3 == 3'd2))) begin
      n_fail++; $display("FAIL read_strobe addr=%h f3=%0d: got %b want %b", addr, f3, rd_seen, !g.fault && !(we && f3 == 3'd2));
    end
    n_tests++;
    if (wr_seen !== g.wr) begin
      n_fail++; $display("FAIL write_strobe addr=%h f3=%0d: got %b want %b", addr, f3, wr_seen, g.wr);
    end else if (g.wr) begin
      n_tests++;
      if (wr_dat !== g.wdata || wr_adr !== g.waddr || wr_cyc !== g.lat - 1) begin
        n_fail++;
        $display("FAIL write_beat: got data %h addr %h cycle %0d want data %h addr %h cycle %0d",
                 wr_dat, wr_adr, wr_cyc, g.wdata, g.waddr, g.lat - 1);
      end
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== g.rdata || rsp_fault !== g.fault) begin
      n_fail++;
      $display("FAIL rsp_hold: got valid %b rdata %h fault %b want valid 0 rdata %h fault %b",
               rsp_valid, rsp_rdata, rsp_fault, g.rdata, g.fault);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write_en !== 1'b0
          || mem_access_addr !== 32'h0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got ready %b rsp %b rd %b we %b addr %h rdata %h fault %b want 1 0 0 0 0 0 0",
                 req_ready, rsp_valid, mem_read, mem_write_en, mem_access_addr, rsp_rdata, rsp_fault);
      end
    end
    rst = 1'b0; req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_read !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_accept: got ready %b rsp %b rd %b want 1 0 0", req_ready, rsp_valid, mem_read);
      end
    end
  endtask

  task automatic test_word();
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, mk(32'h0, 1'b0, 2, 1'b1, 32'hDEADBEEF, 32'h10));
    do_req(1'b0, 3'd2, 32'h10, 32'h0, mk(32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0, 32'h0));
  endtask

  task automatic test_byte();
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, mk(32'h0, 1'b0, 2, 1'b1, 32'h11223344, 32'h10));
    do_req(1'b1, 3'd0, 32'h13, 32'h000000AA, mk(32'h0, 1'b0, 3, 1'b1, 32'hAA223344, 32'h10));
    do_req(1'b0, 3'd0, 32'h13, 32'h0, mk(32'hFFFFFFAA, 1'b0, 2, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd4, 32'h13, 32'h0, mk(32'h000000AA, 1'b0, 2, 1'b0, 32'h0, 32'h0));
  endtask

  task automatic test_half();
    do_req(1'b1, 3'd2, 32'h10, 32'h11223344, mk(32'h0, 1'b0, 2, 1'b1, 32'h11223344, 32'h10));
    do_req(1'b1, 3'd1, 32'h12, 32'h00008001, mk(32'h0, 1'b0, 3, 1'b1, 32'h80013344, 32'h10));
    do_req(1'b0, 3'd1, 32'h12, 32'h0, mk(32'hFFFF8001, 1'b0, 2, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd5, 32'h12, 32'h0, mk(32'h00008001, 1'b0, 2, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd0, 32'h10, 32'h0, mk(32'h00000044, 1'b0, 2, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd0, 32'h11, 32'h0, mk(32'h00000033, 1'b0, 2, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd1, 32'h10, 32'h0, mk(32'h00003344, 1'b0, 2, 1'b0, 32'h0, 32'h0));
  endtask

  task automatic test_fault();
    do_req(1'b0, 3'd2, 32'h11, 32'h0, mk(32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd1, 32'h13, 32'h0, mk(32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0));
    do_req(1'b1, 3'd4, 32'h10, 32'h000000FF, mk(32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd3, 32'h10, 32'h0, mk(32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0));
    do_req(1'b1, 3'd2, 32'h12, 32'h12345678, mk(32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd5, 32'h11, 32'h0, mk(32'h0, 1'b1, 1, 1'b0, 32'h0, 32'h0));
    do_req(1'b0, 3'd2, 32'h10, 32'h0, mk(32'h80013344, 1'b0, 2, 1'b0, 32'h0, 32'h0));
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h11; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rmw_read: got mem_read %b want 1", mem_read); end
    @(negedge clk);
    n_tests++;
    if (mem_write_en !== 1'b1 || mem_write_data !== 32'h80015544) begin
      n_fail++; $display("FAIL rmw_write: got we %b data %h want 1 80015544", mem_write_en, mem_write_data);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_write_en !== 1'b0 || mem_access_addr !== 32'h0) begin
      n_fail++; $display("FAIL rst_gates_write: got we %b addr %h want 0 0", mem_write_en, mem_access_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL aborted_rsp cycle %0d: got rsp_valid %b want 0", i, rsp_valid); end
    end
    do_req(1'b0, 3'd2, 32'h10, 32'h0, mk(32'h80013344, 1'b0, 2, 1'b0, 32'h0, 32'h0));
  endtask

  task automatic test_back_to_back();
    exp_t g;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'h80013344, 1'b0, 2, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_tests++;
      if (req_ready !== (i % 3 == 0)) begin
        n_fail++; $display("FAIL b2b_ready cycle %0d: got %b want %b", i, req_ready, (i % 3 == 0));
      end
      n_tests++;
      if (rsp_valid !== (i % 3 == 2)) begin
        n_fail++; $display("FAIL b2b_rsp cycle %0d: got %b want %b", i, rsp_valid, (i % 3 == 2));
      end
      if (rsp_valid && exp_q.size() > 0) begin
        g = exp_q.pop_front();
        n_tests++;
        if (rsp_rdata !== g.rdata || rsp_fault !== g.fault) begin
          n_fail++; $display("FAIL b2b_data cycle %0d: got %h/%b want %h/%b", i, rsp_rdata, rsp_fault, g.rdata, g.fault);
        end
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t e;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h20 + 32'(i * 4);
      wd = $urandom;
      e = model(1'b1, 3'd2, addr, wd);
      do_req(1'b1, 3'd2, addr, wd, e);
      ref_mem[addr[5:2]] = e.wdata;
    end
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'h20 + 32'($urandom_range(0, 15));
      wd = $urandom;
      e = model(we, f3, addr, wd);
      do_req(we, f3, addr, wd, e);
      if (e.wr) ref_mem[addr[5:2]] = e.wdata;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_fault();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
